// File: rtl/game_pkg.sv
// Shared definitions for the 2048 game datapath.
// Holds the move direction encoding and the move_input FSM state type; the
// game controller and the benches import the same constants.
package game_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StOffer,
    StWaitRelease
  } move_state_t;

endpackage

// File: rtl/move_if.sv
// Move-request handshake between move_input and the game controller.
//   move_valid : a move is offered (driven by move_input)
//   move_ready : the controller accepts the move this cycle
//   dir        : direction of the offered/last move, readable as a level
interface move_if;
  import game_pkg::*;

  logic move_valid;
  logic move_ready;
  dir_t dir;

  modport master (output move_valid, output dir, input move_ready);
  modport slave  (input move_valid, input dir, output move_ready);
endinterface

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchronizer followed by a debouncer.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   raw      : asynchronous button input
//   stable   : debounced level; changes only after DEBOUNCE_CYCLES
//              consecutive cycles of disagreement with the synced input
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    // Any cycle of agreement restarts the count, so short glitches vanish.
    if (sync_q != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/move_input.sv
// Front-end input block for the 2048 game.
// Debounces four pushbuttons, detects presses, arbitrates simultaneous
// presses (up > right > down > left) and offers one move per physical press
// over a valid/ready handshake.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   btn_up .. btn_left: raw asynchronous buttons, active-high
//   mv                : move handshake (master side: move_valid, dir out;
//                       move_ready in)
module move_input
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_right,
  input  logic btn_down,
  input  logic btn_left,
  move_if.master mv
);

  // Bit index equals the direction code.
  logic [3:0] raw;
  logic [3:0] stable;
  logic [3:0] stable_prev_q;
  logic [3:0] press;

  assign raw = {btn_left, btn_down, btn_right, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw[i]),
      .stable(stable[i])
    );
  end

  assign press = stable & ~stable_prev_q;

  dir_t win_dir;

  always_comb begin
    if (press[0]) begin
      win_dir = DIR_UP;
    end else if (press[1]) begin
      win_dir = DIR_RIGHT;
    end else if (press[2]) begin
      win_dir = DIR_DOWN;
    end else begin
      win_dir = DIR_LEFT;
    end
  end

  move_state_t state_q, state_d;
  dir_t        dir_q, dir_d;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        if (|press) begin
          dir_d   = win_dir;
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (mv.move_ready) begin
          state_d = StWaitRelease;
        end
      end
      StWaitRelease: begin
        // Holding or bouncing any button blocks further moves.
        if (stable == 4'b0000) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      dir_q         <= DIR_UP;
      stable_prev_q <= 4'b0000;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      stable_prev_q <= stable;
    end
  end

  // Decoded from the state register only: no path from move_ready, and the
  // asynchronous reset drops move_valid immediately.
  assign mv.move_valid = (state_q == StOffer);
  assign mv.dir        = dir_q;

endmodule

// File: tb/tb_move_input.sv
// Directed self-checking bench for move_input with DEBOUNCE_CYCLES = 4.
module tb_move_input;
  import game_pkg::*;

  logic clk;
  logic rst;
  logic btn_up, btn_right, btn_down, btn_left;
  int   errors;
  int   checks;
  int   pulses;
  logic [1:0] seen_dir;

  move_if mif ();

  move_input #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_right(btn_right),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .mv       (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; sample and drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count cycles with move_valid high over n edges; record the last dir offered.
  task automatic window(input int n, output int cnt, output logic [1:0] last_dir);
    cnt      = 0;
    last_dir = 2'd3;
    for (int i = 0; i < n; i++) begin
      tick();
      if (mif.move_valid === 1'b1) begin
        cnt++;
        last_dir = mif.dir;
      end
    end
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    rst            = 1'b0;
    btn_up         = 1'b1;
    btn_right      = 1'b1;
    btn_down       = 1'b1;
    btn_left       = 1'b1;
    mif.move_ready = 1'b0;

    // Reset held with all buttons high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", 32'(mif.move_valid), 32'd0);
      chk("rst_dir", 32'(mif.dir), 32'd0);
    end
    rst = 1'b1;
    repeat (6) tick();
    chk("rst_rel_valid_early", 32'(mif.move_valid), 32'd0);
    tick();
    chk("rst_rel_valid", 32'(mif.move_valid), 32'd1);
    chk("rst_rel_dir_up_wins", 32'(mif.dir), 32'(DIR_UP));
    mif.move_ready = 1'b1;
    tick();
    chk("rst_rel_accept", 32'(mif.move_valid), 32'd0);
    btn_up = 1'b0; btn_right = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
    repeat (10) tick();
    chk("rst_rel_idle", 32'(dut.state_q), 32'(StIdle));

    // Single press, immediate accept.
    btn_down = 1'b1;
    repeat (6) tick();
    chk("down_valid_early", 32'(mif.move_valid), 32'd0);
    tick();
    chk("down_valid", 32'(mif.move_valid), 32'd1);
    chk("down_dir", 32'(mif.dir), 32'(DIR_DOWN));
    tick();
    chk("down_one_cycle", 32'(mif.move_valid), 32'd0);
    window(10, pulses, seen_dir);
    chk("down_held_no_repeat", 32'(pulses), 32'd0);
    chk("down_dir_kept", 32'(mif.dir), 32'(DIR_DOWN));
    btn_down = 1'b0;
    repeat (10) tick();

    // Backpressure, button released during the offer.
    mif.move_ready = 1'b0;
    btn_left = 1'b1;
    repeat (7) tick();
    chk("left_valid", 32'(mif.move_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) btn_left = 1'b0;
      tick();
      chk("left_hold_valid", 32'(mif.move_valid), 32'd1);
      chk("left_hold_dir", 32'(mif.dir), 32'(DIR_LEFT));
    end
    mif.move_ready = 1'b1;
    tick();
    chk("left_accept", 32'(mif.move_valid), 32'd0);
    window(12, pulses, seen_dir);
    chk("left_single_transfer", 32'(pulses), 32'd0);
    chk("left_dir_kept", 32'(mif.dir), 32'(DIR_LEFT));

    // Glitch rejection: 3-cycle pulse ignored, 5-cycle pulse accepted.
    btn_up = 1'b1;
    repeat (3) tick();
    btn_up = 1'b0;
    window(15, pulses, seen_dir);
    chk("glitch3_no_move", 32'(pulses), 32'd0);
    btn_up = 1'b1;
    repeat (5) tick();
    btn_up = 1'b0;
    window(20, pulses, seen_dir);
    chk("pulse5_one_move", 32'(pulses), 32'd1);
    chk("pulse5_dir", 32'(seen_dir), 32'(DIR_UP));

    // Simultaneous left + right: right wins, no second move until released.
    btn_left  = 1'b1;
    btn_right = 1'b1;
    window(15, pulses, seen_dir);
    chk("simul_one_move", 32'(pulses), 32'd1);
    chk("simul_dir_right", 32'(seen_dir), 32'(DIR_RIGHT));
    btn_right = 1'b0;
    window(15, pulses, seen_dir);
    chk("simul_left_held_no_move", 32'(pulses), 32'd0);
    btn_left = 1'b0;
    window(10, pulses, seen_dir);
    chk("simul_released_no_move", 32'(pulses), 32'd0);
    btn_right = 1'b1;
    window(15, pulses, seen_dir);
    chk("repress_one_move", 32'(pulses), 32'd1);
    chk("repress_dir", 32'(seen_dir), 32'(DIR_RIGHT));
    btn_right = 1'b0;
    repeat (10) tick();

    // Asynchronous reset during OFFER.
    mif.move_ready = 1'b0;
    btn_down = 1'b1;
    repeat (7) tick();
    chk("areset_offer_valid", 32'(mif.move_valid), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("areset_valid_drop", 32'(mif.move_valid), 32'd0);
    chk("areset_state_idle", 32'(dut.state_q), 32'(StIdle));
    chk("areset_dir_clear", 32'(mif.dir), 32'd0);
    tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("areset_held_early", 32'(mif.move_valid), 32'd0);
    tick();
    chk("areset_held_new_press", 32'(mif.move_valid), 32'd1);
    chk("areset_held_dir", 32'(mif.dir), 32'(DIR_DOWN));
    mif.move_ready = 1'b1;
    tick();
    chk("areset_accept", 32'(mif.move_valid), 32'd0);
    btn_down = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
